keyboard_port: RTL



---
 rtl/keyboard_pkg.sv | 51 +++++
 rtl/kbd_fifo_mem.sv | 33 +++
 rtl/keyboard_port.sv | 122 ++++++++++++
 3 files changed

// File: rtl/keyboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keyboard_pkg
//  Description : Shared constants, register-select encoding and the key
//                normalisation helpers for the Apple-1 keyboard port.
//  Revision    : 1.0  initial release
// ============================================================================
package keyboard_pkg;

    // Bit positions inside the KBDCR status byte
    localparam int READY = 7;
    localparam int OVF   = 0;

    // Bit 7 set on the data byte marks a valid Apple-1 key
    localparam logic [7:0] KBD_READY_MASK = 8'h80;

    // Character constants, 7-bit ASCII
    localparam logic [6:0] LF         = 7'h0A;
    localparam logic [6:0] DEL        = 7'h7F;
    localparam logic [6:0] UNDERSCORE = 7'h5F;

    // Lower-case range folded onto upper case
    localparam logic [6:0] LOWER_A    = 7'h61;
    localparam logic [6:0] LOWER_Z    = 7'h7A;
    localparam logic [6:0] CASE_DELTA = 7'h20;

    // CPU register select on the single address line
    typedef enum logic {
        ADDR_KBD   = 1'b0,
        ADDR_KBDCR = 1'b1
    } kbd_reg_e;

    // Map a 7-bit key to the Apple-1 upper-case character set
    function automatic logic [6:0] kbd_normalise(input logic [6:0] k);
        logic [6:0] r;
        r = k;
        if ((k >= LOWER_A) && (k <= LOWER_Z)) begin
            r = k - CASE_DELTA;
        end else if (k == DEL) begin
            r = UNDERSCORE;
        end
        return r;
    endfunction

    // Line feed is swallowed: the Apple-1 only ever uses CR
    function automatic logic kbd_is_dropped(input logic [6:0] k);
        return (k == LF);
    endfunction

endpackage : keyboard_pkg
`default_nettype wire

// File: rtl/kbd_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_fifo_mem
//  Description : DEPTH x 7 key storage, one synchronous write port and one
//                asynchronous read port.
//  Revision    : 1.0  initial release
// ============================================================================
module kbd_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [6:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [6:0]    rdata
);

    logic [6:0] r_mem [DEPTH];

    // Store one key per accepted push; contents need no reset, the
    // pointers and count decide what is valid
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : kbd_fifo_mem
`default_nettype wire

// File: rtl/keyboard_port.sv
`default_nettype none
// ============================================================================
//  Module      : keyboard_port
//  Description : Apple-1 keyboard input: normalises host key bytes, buffers
//                them in a FIFO and exposes the PIA KBD / KBDCR pair.
//  Revision    : 1.0  initial release
// ============================================================================
module keyboard_port
    import keyboard_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_clken,
    input  logic       key_valid,
    input  logic [7:0] key_data,
    output logic       key_ready,
    input  logic       kbd_flush,
    input  logic       address,
    input  logic       r_en,
    output logic [7:0] dout
);

    localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;

    logic          w_empty;
    logic          w_full;
    logic [6:0]    w_key;
    logic [6:0]    w_norm;
    logic          w_drop;
    logic          w_pop;
    logic          w_push;
    logic          w_status_rd;
    logic          w_ovf_set;
    logic          w_we;
    logic [6:0]    w_head;
    logic          w_unused_bit7;

    // Bit 7 of the host byte carries no meaning for the Apple-1
    assign w_unused_bit7 = key_data[7];

    assign w_key   = key_data[6:0];
    assign w_norm  = kbd_normalise(w_key);
    assign w_drop  = kbd_is_dropped(w_key);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    assign w_pop       = cpu_clken & r_en & (address == ADDR_KBD) & ~w_empty;
    assign key_ready   = ~w_full | w_pop;
    assign w_push      = key_valid & key_ready & ~w_drop;
    assign w_status_rd = cpu_clken & r_en & (address == ADDR_KBDCR);
    assign w_ovf_set   = key_valid & w_full & ~w_pop;
    assign w_we        = w_push & ~kbd_flush;

    kbd_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_ptr),
        .wdata (w_norm),
        .raddr (r_rd_ptr),
        .rdata (w_head)
    );

    // Pointer and occupancy bookkeeping; flush behaves exactly like reset
    always_ff @(posedge clk) begin
        if (reset || kbd_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - C_CNT_ONE;
            end
        end
    end

    // Sticky overflow flag: a new loss beats a simultaneous status read
    always_ff @(posedge clk) begin
        if (reset || kbd_flush) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_status_rd) begin
            r_ovf <= 1'b0;
        end
    end

    // CPU read mux, no latency
    always_comb begin
        dout = 8'h00;
        if (address == ADDR_KBDCR) begin
            dout[READY] = ~w_empty;
            dout[OVF]   = r_ovf;
        end else if (!w_empty) begin
            dout = KBD_READY_MASK | {1'b0, w_head};
        end
    end

endmodule : keyboard_port
`default_nettype wire
